// File: rtl/logcap_pkg.sv
// Shared opcode, status-bit and FSM definitions for the capture-side command responder.
package logcap_pkg;

  localparam logic [7:0] CMD_NOP         = 8'h00;
  localparam logic [7:0] CMD_SOFT_RESET  = 8'h01;
  localparam logic [7:0] CMD_SET_TRIGGER = 8'h02;
  localparam logic [7:0] CMD_ARM         = 8'h03;
  localparam logic [7:0] CMD_ABORT       = 8'h04;
  localparam logic [7:0] CMD_READ_SAMPLE = 8'h05;
  localparam logic [7:0] CMD_READ_COUNT  = 8'h06;

  localparam int unsigned STS_CMD_BUSY      = 0;
  localparam int unsigned STS_CMD_ERROR     = 1;
  localparam int unsigned STS_RESULT_VALID  = 2;
  localparam int unsigned STS_CAP_BUSY      = 3;
  localparam int unsigned STS_CAP_TRIGGERED = 4;
  localparam int unsigned STS_CAP_DONE      = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

endpackage

// File: rtl/logcap_command_responder.sv
// Capture-side command responder: decodes hub commands, drives the capture engine,
// reads capture RAM and publishes results and status back to the hub.
module logcap_command_responder
  import logcap_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                command_strobe,
  input  logic [7:0]          command,
  input  logic [7:0]          op0,
  input  logic [7:0]          op1,
  input  logic [7:0]          op2,
  input  logic [7:0]          op3,
  input  logic [7:0]          op4,
  input  logic [7:0]          op5,
  input  logic [7:0]          op6,
  input  logic [7:0]          op7,
  output logic [7:0]          res0,
  output logic [7:0]          res1,
  output logic [7:0]          res2,
  output logic [7:0]          res3,
  output logic [7:0]          res4,
  output logic [7:0]          res5,
  output logic [7:0]          res6,
  output logic [7:0]          res7,
  output logic [7:0]          status,
  output logic                cap_arm,
  output logic                cap_abort,
  output logic [SAMPLE_W-1:0] trig_mask,
  output logic [SAMPLE_W-1:0] trig_value,
  input  logic                cap_busy,
  input  logic                cap_triggered,
  input  logic                cap_done,
  input  logic [ADDR_W:0]     cap_count,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_rdata
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_strobe_q;
  logic                 w_edge;
  logic                 w_accept;
  logic                 w_overrun;
  logic [7:0]           r_cmd;
  logic [63:0]          r_ops;
  logic [MEM_LAT-1:0]   r_lat_sr;
  logic [63:0]          r_res;
  logic                 r_cmd_error;
  logic                 r_result_valid;
  logic                 r_cap_busy_q;
  logic                 r_cap_trig_q;
  logic                 r_cap_done_q;

  assign w_edge = command_strobe & ~r_strobe_q;

  // Strobe history for edge detection and one-cycle registration of capture status inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_strobe_q   <= 1'b0;
      r_cap_busy_q <= 1'b0;
      r_cap_trig_q <= 1'b0;
      r_cap_done_q <= 1'b0;
    end else begin
      r_strobe_q   <= command_strobe;
      r_cap_busy_q <= cap_busy;
      r_cap_trig_q <= cap_triggered;
      r_cap_done_q <= cap_done;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state plus accept/overrun classification of strobe edges
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_overrun   = w_edge;
        w_state_nxt = (r_cmd == CMD_READ_SAMPLE) ? ST_MEM_WAIT : ST_IDLE;
      end
      ST_MEM_WAIT: begin
        w_overrun = w_edge;
        if (r_lat_sr[MEM_LAT-1]) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_overrun   = w_edge;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, opcode execution, RAM read sequencing and result update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd          <= '0;
      r_ops          <= '0;
      r_lat_sr       <= '0;
      r_res          <= '0;
      r_cmd_error    <= 1'b0;
      r_result_valid <= 1'b0;
      cap_arm        <= 1'b0;
      cap_abort      <= 1'b0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      trig_mask      <= '0;
      trig_value     <= '0;
    end else begin
      cap_arm   <= 1'b0;
      cap_abort <= 1'b0;
      mem_rd    <= 1'b0;
      if (w_accept) begin
        r_cmd          <= command;
        r_ops          <= {op7, op6, op5, op4, op3, op2, op1, op0};
        r_cmd_error    <= 1'b0;
        r_result_valid <= 1'b0;
      end
      if (w_overrun) r_cmd_error <= 1'b1;
      if (r_state == ST_EXEC) begin
        case (r_cmd)
          CMD_NOP: begin
          end
          CMD_SOFT_RESET: begin
            r_res      <= '0;
            trig_mask  <= '0;
            trig_value <= '0;
            cap_abort  <= 1'b1;
          end
          CMD_SET_TRIGGER: begin
            trig_value <= r_ops[SAMPLE_W-1:0];
            trig_mask  <= r_ops[32 +: SAMPLE_W];
          end
          CMD_ARM: begin
            if (cap_busy) r_cmd_error <= 1'b1;
            else          cap_arm     <= 1'b1;
          end
          CMD_ABORT: cap_abort <= 1'b1;
          CMD_READ_SAMPLE: begin
            mem_addr <= r_ops[ADDR_W-1:0];
            mem_rd   <= 1'b1;
            r_lat_sr <= MEM_LAT'(1);
          end
          CMD_READ_COUNT: begin
            r_res          <= {48'h0, 16'(cap_count)};
            r_result_valid <= 1'b1;
          end
          default: r_cmd_error <= 1'b1;
        endcase
      end
      // One-hot token walks towards the MSB once per wait cycle; MSB set means data is due next edge
      if (r_state == ST_MEM_WAIT) r_lat_sr <= r_lat_sr << 1;
      if (r_state == ST_LATCH) begin
        r_res          <= {16'h0, 16'(mem_addr), 32'(mem_rdata)};
        r_result_valid <= 1'b1;
      end
    end
  end

  // Status byte assembly
  always_comb begin
    status                    = '0;
    status[STS_CMD_BUSY]      = (r_state != ST_IDLE);
    status[STS_CMD_ERROR]     = r_cmd_error;
    status[STS_RESULT_VALID]  = r_result_valid;
    status[STS_CAP_BUSY]      = r_cap_busy_q;
    status[STS_CAP_TRIGGERED] = r_cap_trig_q;
    status[STS_CAP_DONE]      = r_cap_done_q;
  end

  assign res0 = r_res[7:0];
  assign res1 = r_res[15:8];
  assign res2 = r_res[23:16];
  assign res3 = r_res[31:24];
  assign res4 = r_res[39:32];
  assign res5 = r_res[47:40];
  assign res6 = r_res[55:48];
  assign res7 = r_res[63:56];

endmodule

// File: tb/tb_logcap_command_responder.sv
// Scoreboard bench for logcap_command_responder: stimulus pushes expected completions,
// a monitor pops and compares them whenever cmd_busy falls.
module tb_logcap_command_responder;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned MEM_LAT  = 2;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [31:0] tv;
    logic [31:0] tm;
    logic [7:0]  sts;
    int          busy_n;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                command_strobe;
  logic [7:0]          command;
  logic [7:0]          op [8];
  logic [7:0]          res0, res1, res2, res3, res4, res5, res6, res7;
  logic [7:0]          status;
  logic                cap_arm, cap_abort;
  logic [SAMPLE_W-1:0] trig_mask, trig_value;
  logic                cap_busy, cap_triggered, cap_done;
  logic [ADDR_W:0]     cap_count;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_rdata;

  logic                v1 = 1'b0, v2 = 1'b0;
  logic [31:0]         d1 = '0, d2 = '0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_arm = 0, n_abort = 0, n_rd = 0, n_both = 0;

  always #5 clk = ~clk;

  logcap_command_responder #(
    .SAMPLE_W(SAMPLE_W),
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .command_strobe(command_strobe), .command(command),
    .op0(op[0]), .op1(op[1]), .op2(op[2]), .op3(op[3]),
    .op4(op[4]), .op5(op[5]), .op6(op[6]), .op7(op[7]),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .res4(res4), .res5(res5), .res6(res6), .res7(res7),
    .status(status), .cap_arm(cap_arm), .cap_abort(cap_abort),
    .trig_mask(trig_mask), .trig_value(trig_value),
    .cap_busy(cap_busy), .cap_triggered(cap_triggered), .cap_done(cap_done),
    .cap_count(cap_count), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
    if (a == 12'h123) return 32'hDEAD_BEEF;
    return {4'hC, a, 4'h3, ~a};
  endfunction

  // Two-stage RAM model: data is only valid in the single cycle MEM_LAT edges after mem_rd
  always @(posedge clk) begin
    v1 <= mem_rd;
    d1 <= ram_word(mem_addr);
    v2 <= v1;
    d2 <= d1;
  end
  assign mem_rdata = v2 ? d2 : 32'hBAD0_BAD0;

  function automatic logic [63:0] res_vec();
    return {res7, res6, res5, res4, res3, res2, res1, res0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard comparison at every cmd_busy falling edge
  initial begin
    int  busy_cnt;
    bit  prev_busy;
    exp_t e;
    busy_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cap_arm)              n_arm++;
      if (cap_abort)            n_abort++;
      if (mem_rd)               n_rd++;
      if (cap_arm && cap_abort) n_both++;
      if (!reset) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (status[0]) busy_cnt++;
        else if (prev_busy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_res"},     res_vec(),         e.res);
            check({e.name, "_status"},  64'(status),       64'(e.sts));
            check({e.name, "_trigval"}, 64'(trig_value),   64'(e.tv));
            check({e.name, "_trigmsk"}, 64'(trig_mask),    64'(e.tm));
            check({e.name, "_busycyc"}, 64'(busy_cnt),     64'(e.busy_n));
          end
          busy_cnt = 0;
        end
        prev_busy = status[0];
      end
    end
  end

  task automatic drive_ops(input logic [63:0] ops);
    for (int i = 0; i < 8; i++) op[i] = ops[8*i +: 8];
  endtask

  task automatic push_exp(input string nm, input logic [63:0] r, input logic [31:0] tv,
                          input logic [31:0] tm, input logic [7:0] sts, input int bn);
    exp_t e;
    e.name = nm; e.res = r; e.tv = tv; e.tm = tm; e.sts = sts; e.busy_n = bn;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!status[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_idle"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic send(input string nm, input logic [7:0] cmd, input logic [63:0] ops,
                      input int hold, input logic [63:0] r, input logic [31:0] tv,
                      input logic [31:0] tm, input logic [7:0] sts, input int bn);
    push_exp(nm, r, tv, tm, sts, bn);
    @(negedge clk);
    command = cmd;
    drive_ops(ops);
    command_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    command_strobe = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    int snap;
    reset = 1'b0; command_strobe = 1'b0; command = '0; drive_ops('0);
    cap_busy = 1'b0; cap_triggered = 1'b0; cap_done = 1'b0; cap_count = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_res",     res_vec(),                              64'h0);
    check("rst_status",  64'(status),                            64'h0);
    check("rst_trig",    {trig_mask, trig_value},                64'h0);
    check("rst_outs",    64'({cap_arm, cap_abort, mem_rd, mem_addr}), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Trigger registers from the operand bytes
    send("set_trigger", 8'h02, 64'h00FF_00FF_1234_5678, 1,
         64'h0, 32'h1234_5678, 32'h00FF_00FF, 8'h00, 1);

    // Sample read: 4 bytes LSB first, then address echo; busy spans MEM_LAT+2 samples
    snap = n_rd;
    send("read_123", 8'h05, 64'h0000_0000_0000_0123, 1,
         64'h0000_0123_DEAD_BEEF, 32'h1234_5678, 32'h00FF_00FF, 8'h04, 4);
    check("read_rd_pulses", 64'(n_rd - snap), 64'd1);

    // Reset asserted during MEM_WAIT of a read: everything clears, nothing fires afterwards
    @(negedge clk);
    command = 8'h05; drive_ops(64'h45); command_strobe = 1'b1;
    @(negedge clk);
    command_strobe = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_res",    res_vec(),               64'h0);
    check("midrst_status", 64'(status),             64'h0);
    check("midrst_trig",   {trig_mask, trig_value}, 64'h0);
    check("midrst_outs",   64'({cap_arm, cap_abort, mem_rd, mem_addr}), 64'h0);
    snap = n_rd + n_arm + n_abort;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("midrst_no_pulses", 64'(n_rd + n_arm + n_abort - snap), 64'd0);
    check("midrst_idle",      64'(status),                        64'h0);
    check("midrst_res_after", res_vec(),                          64'h0);

    // ARM with strobe held three cycles: a single pulse
    snap = n_arm;
    send("arm_held", 8'h03, 64'h0, 3, 64'h0, 32'h0, 32'h0, 8'h00, 1);
    check("arm_held_pulses", 64'(n_arm - snap), 64'd1);

    // ARM while the engine is busy: error, no pulse, cap_busy visible in status
    cap_busy = 1'b1;
    repeat (2) @(negedge clk);
    snap = n_arm;
    send("arm_busy", 8'h03, 64'h0, 1, 64'h0, 32'h0, 32'h0, 8'h0A, 1);
    check("arm_busy_pulses", 64'(n_arm - snap), 64'd0);
    cap_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Second edge during the read's MEM_WAIT: dropped as overrun, read still completes
    push_exp("read_overrun", 64'h0000_00AB_C0AB_3F54, 32'h0, 32'h0, 8'h06, 4);
    @(negedge clk);
    command = 8'h05; drive_ops(64'h00AB); command_strobe = 1'b1;
    @(negedge clk);
    command_strobe = 1'b0;
    @(negedge clk);
    command = 8'h06; command_strobe = 1'b1;
    @(negedge clk);
    command_strobe = 1'b0;
    wait_idle("read_overrun");
    check("overrun_sb_empty", 64'(sb_q.size()), 64'd0);

    // Unknown opcode leaves results alone; the next good command clears the error
    send("bad_opcode", 8'h7E, 64'h0, 1, 64'h0000_00AB_C0AB_3F54, 32'h0, 32'h0, 8'h02, 1);
    cap_count = 13'h1FFF;
    send("read_count", 8'h06, 64'h0, 1, 64'h0000_0000_0000_1FFF, 32'h0, 32'h0, 8'h04, 1);

    // Capture status inputs reflected in the status byte
    cap_triggered = 1'b1; cap_done = 1'b1;
    repeat (2) @(negedge clk);
    send("nop_caps", 8'h00, 64'h0, 1, 64'h1FFF, 32'h0, 32'h0, 8'h30, 1);
    cap_triggered = 1'b0; cap_done = 1'b0;
    repeat (2) @(negedge clk);

    snap = n_abort;
    send("abort", 8'h04, 64'h0, 1, 64'h1FFF, 32'h0, 32'h0, 8'h00, 1);
    check("abort_pulses", 64'(n_abort - snap), 64'd1);

    send("set_trigger2", 8'h02, 64'h8877_6655_4433_2211, 1,
         64'h1FFF, 32'h4433_2211, 32'h8877_6655, 8'h00, 1);
    snap = n_abort;
    send("soft_reset", 8'h01, 64'h0, 1, 64'h0, 32'h0, 32'h0, 8'h00, 1);
    check("soft_reset_pulses", 64'(n_abort - snap), 64'd1);

    check("final_sb_empty",   64'(sb_q.size()), 64'd0);
    check("arm_abort_overlap", 64'(n_both),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
